// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a local command/response handshake
// into AXI-Lite write or read transactions, with a per-state timeout guard.
module axi_lite_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,

    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,

    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    input  logic              WREADY,

    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,

    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,

    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              awvalid_q, awvalid_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;

    logic timed_out;
    logic aw_done;
    logic w_done;
    logic abort;

    // The last permitted waiting cycle is reached when the count hits TIMEOUT-1.
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign aw_done   = !awvalid_q || AWREADY;
    assign w_done    = !wvalid_q  || WREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        abort       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    cnt_d       = '0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end

            // AW and W retire independently; a completed handshake wins over a same-cycle timeout.
            WR_AW_W: begin
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WR_B;
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WR_B: begin
                if (BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = BRESP;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // RVALID seen alongside ARREADY is not consumed here; RD_R samples it again.
            RD_AR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = RD_R;
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RD_R: begin
                if (RVALID) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A hung slave: release the bus and report the local timeout code.
        if (abort) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_write_d = (state_q == WR_AW_W) || (state_q == WR_B);
            rsp_rdata_d = '0;
            rsp_resp_d  = RESP_TIMEOUT;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign AWADDR    = awaddr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a small configurable AXI-Lite slave with memory,
// table-driven transactions, and hand-written sequences for multi-cycle corners.
module tb_axi_lite_master;

    logic        ACLK;
    logic        ARESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int tests_run    = 0;
    int tests_failed = 0;

    axi_lite_master #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_resp (rsp_resp),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Slave knobs, written only by the stimulus side.
    int unsigned cfg_aw_wait = 0;
    int unsigned cfg_w_wait  = 0;
    int unsigned cfg_ar_wait = 0;
    bit          cfg_ar_never = 1'b0;
    bit          cfg_r_early  = 1'b0;
    bit          cfg_b_hold   = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;

    // Slave state. Everything runs on the falling edge: what is driven here is
    // exactly what the DUT samples at the following rising edge.
    int unsigned aw_cnt, w_cnt, ar_cnt;
    bit          aw_got, w_got, ar_got, b_hs, r_hs, mem_ready;
    logic [31:0] aw_cap, w_cap, ar_cap;
    logic [31:0] mem [16];
    int          b_count = 0;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
            ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0;    RRESP = 2'b00;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
            if (!mem_ready) begin
                for (int i = 0; i < 16; i++) mem[i] = '0;
                mem_ready = 1'b1;
            end
        end else begin
            if (b_hs) begin BVALID = 1'b0; b_count++; end
            if (r_hs) RVALID = 1'b0;
            if (cmd_ready) begin aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; end
            if (aw_got && w_got && !BVALID && !cfg_b_hold) begin
                mem[aw_cap[5:2]] = w_cap;
                BVALID = 1'b1; BRESP = cfg_bresp;
                aw_got = 1'b0; w_got = 1'b0;
            end
            if (ar_got && !RVALID) begin
                RVALID = 1'b1; RDATA = mem[ar_cap[5:2]]; RRESP = cfg_rresp;
                ar_got = 1'b0;
            end
            if (AWVALID && !aw_got) begin AWREADY = (aw_cnt >= cfg_aw_wait); aw_cnt++; end
            else begin AWREADY = 1'b0; aw_cnt = 0; end
            if (WVALID && !w_got) begin WREADY = (w_cnt >= cfg_w_wait); w_cnt++; end
            else begin WREADY = 1'b0; w_cnt = 0; end
            if (ARVALID && !ar_got) begin ARREADY = !cfg_ar_never && (ar_cnt >= cfg_ar_wait); ar_cnt++; end
            else begin ARREADY = 1'b0; ar_cnt = 0; end
            if (AWVALID && AWREADY) begin aw_got = 1'b1; aw_cap = AWADDR; end
            if (WVALID && WREADY)   begin w_got = 1'b1;  w_cap = WDATA;   end
            if (ARVALID && ARREADY) begin
                if (cfg_r_early) begin
                    RVALID = 1'b1; RDATA = mem[ARADDR[5:2]]; RRESP = cfg_rresp;
                end else begin
                    ar_got = 1'b1; ar_cap = ARADDR;
                end
            end
            b_hs = BVALID && BREADY;
            r_hs = RVALID && RREADY;
        end
    end

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned aw_wait;
        int unsigned w_wait;
        int unsigned ar_wait;
        bit          ar_never;
        bit          r_early;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        int          rsp_hold;
        bit          exp_write;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic setSlave(input int unsigned aw_w, input int unsigned w_w, input int unsigned ar_w,
                            input bit ar_nv, input bit r_er, input logic [1:0] br, input logic [1:0] rr);
        cfg_aw_wait  = aw_w;
        cfg_w_wait   = w_w;
        cfg_ar_wait  = ar_w;
        cfg_ar_never = ar_nv;
        cfg_r_early  = r_er;
        cfg_bresp    = br;
        cfg_rresp    = rr;
        cfg_b_hold   = 1'b0;
    endtask

    // Called on a falling edge while the DUT is idle; returns one cycle after the handshake.
    task automatic issueCmd(input string name, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        checkOutput({name, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int    lat;
        string nm;
        nm = $sformatf("v%0d", idx);
        setSlave(v.aw_wait, v.w_wait, v.ar_wait, v.ar_never, v.r_early, v.bresp, v.rresp);
        issueCmd(nm, v.write, v.addr, v.wdata);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 30) begin
            @(negedge ACLK);
            lat++;
        end
        if (rsp_valid !== 1'b1) begin
            checkOutput({nm, " rsp_valid arrival"}, 32'(rsp_valid), 32'd1);
            return;
        end
        checkOutput({nm, " latency"}, lat, v.exp_lat);
        checkOutput({nm, " rsp_write"}, 32'(rsp_write), 32'(v.exp_write));
        checkOutput({nm, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        checkOutput({nm, " rsp_resp"}, 32'(rsp_resp), 32'(v.exp_resp));
        for (int k = 0; k < v.rsp_hold; k++) begin
            @(negedge ACLK);
            checkOutput({nm, " held rsp_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({nm, " held rsp_rdata"}, rsp_rdata, v.exp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        checkOutput({nm, " rsp_valid after accept"}, 32'(rsp_valid), 32'd0);
        checkOutput({nm, " cmd_ready after accept"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ARESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;

        //            wr    addr        wdata         aw w  ar nv   er    bresp  rresp  hold wr    rdata         resp   lat
        vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b1, 32'h0,        2'b00, 3};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,        0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00, 2, 1'b0, 32'hDEADBEEF, 2'b00, 3};
        vecs[2]  = '{1'b1, 32'h14, 32'h12345678, 2, 0, 0, 1'b0, 1'b0, 2'b10, 2'b00, 0, 1'b1, 32'h0,        2'b10, 5};
        vecs[3]  = '{1'b1, 32'h18, 32'hA5A5A5A5, 0, 3, 0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b1, 32'h0,        2'b00, 6};
        vecs[4]  = '{1'b0, 32'h14, 32'h0,        0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0, 32'h12345678, 2'b00, 3};
        vecs[5]  = '{1'b0, 32'h18, 32'h0,        0, 0, 2, 1'b0, 1'b0, 2'b00, 2'b10, 0, 1'b0, 32'hA5A5A5A5, 2'b10, 5};
        vecs[6]  = '{1'b0, 32'h10, 32'h0,        0, 0, 0, 1'b0, 1'b1, 2'b00, 2'b00, 0, 1'b0, 32'hDEADBEEF, 2'b00, 3};
        vecs[7]  = '{1'b1, 32'h1C, 32'h0BADF00D, 1, 1, 0, 1'b0, 1'b0, 2'b01, 2'b00, 0, 1'b1, 32'h0,        2'b01, 4};
        vecs[8]  = '{1'b0, 32'h1C, 32'h0,        0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b01, 0, 1'b0, 32'h0BADF00D, 2'b01, 3};
        vecs[9]  = '{1'b0, 32'h2C, 32'h0,        0, 0, 0, 1'b1, 1'b0, 2'b00, 2'b00, 0, 1'b0, 32'h0,        2'b11, 9};
        vecs[10] = '{1'b1, 32'h28, 32'hCAFEF00D, 20,0, 0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b1, 32'h0,        2'b11, 9};
        vecs[11] = '{1'b0, 32'h20, 32'h0,        0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0, 32'h11223344, 2'b00, 3};
        vecs[12] = '{1'b0, 32'h28, 32'h0,        0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0, 32'h0,        2'b00, 3};

        repeat (3) @(negedge ACLK);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset valids", {26'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 32'd0);
        checkOutput("reset AWADDR", AWADDR, 32'd0);
        checkOutput("reset WDATA", WDATA, 32'd0);
        checkOutput("reset ARADDR", ARADDR, 32'd0);
        checkOutput("reset rsp fields", {29'd0, rsp_write, rsp_resp}, 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // AW accepted immediately, W held off three cycles, then a held response.
        setSlave(0, 3, 0, 1'b0, 1'b0, 2'b00, 2'b00);
        issueCmd("wseq", 1'b1, 32'h20, 32'h11223344);
        checkOutput("wseq c1 AWVALID", 32'(AWVALID), 32'd1);
        checkOutput("wseq c1 WVALID", 32'(WVALID), 32'd1);
        checkOutput("wseq c1 AWADDR", AWADDR, 32'h20);
        checkOutput("wseq c1 WDATA", WDATA, 32'h11223344);
        @(negedge ACLK);
        checkOutput("wseq c2 AWVALID", 32'(AWVALID), 32'd0);
        checkOutput("wseq c2 WVALID", 32'(WVALID), 32'd1);
        checkOutput("wseq c2 BREADY", 32'(BREADY), 32'd0);
        repeat (2) @(negedge ACLK);
        checkOutput("wseq c4 WVALID", 32'(WVALID), 32'd1);
        @(negedge ACLK);
        checkOutput("wseq c5 WVALID", 32'(WVALID), 32'd0);
        checkOutput("wseq c5 BREADY", 32'(BREADY), 32'd1);
        @(negedge ACLK);
        checkOutput("wseq c6 rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wseq c6 BREADY", 32'(BREADY), 32'd0);
        checkOutput("wseq c6 ARVALID", 32'(ARVALID), 32'd0);

        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("hold%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("hold%0d rsp_write", k), 32'(rsp_write), 32'd1);
            checkOutput($sformatf("hold%0d rsp_resp", k), 32'(rsp_resp), 32'd0);
            checkOutput($sformatf("hold%0d rsp_rdata", k), rsp_rdata, 32'd0);
            checkOutput($sformatf("hold%0d cmd_ready", k), 32'(cmd_ready), 32'd0);
            cmd_valid = (k == 2);
            cmd_write = 1'b0;
            cmd_addr  = 32'h10;
            @(negedge ACLK);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        checkOutput("hold accept rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("hold accept cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("hold pulse ignored ARVALID", 32'(ARVALID), 32'd0);
        @(negedge ACLK);
        checkOutput("hold pulse ignored ARVALID+1", 32'(ARVALID), 32'd0);
        checkOutput("wseq single B", b_count, 32'd1);

        for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);

        // Read timeout waveform: ARVALID held for exactly eight cycles.
        setSlave(0, 0, 0, 1'b1, 1'b0, 2'b00, 2'b00);
        issueCmd("tmo", 1'b0, 32'h30, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("tmo c%0d ARVALID", k), 32'(ARVALID), 32'd1);
            @(negedge ACLK);
        end
        checkOutput("tmo c9 ARVALID", 32'(ARVALID), 32'd0);
        checkOutput("tmo c9 rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("tmo c9 rsp_resp", 32'(rsp_resp), 32'd3);
        checkOutput("tmo c9 rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("tmo c9 ARADDR held", ARADDR, 32'h30);
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        checkOutput("tmo accept cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset while waiting for B aborts the write without a response.
        setSlave(0, 0, 0, 1'b0, 1'b0, 2'b00, 2'b00);
        cfg_b_hold = 1'b1;
        issueCmd("rst", 1'b1, 32'h24, 32'h55AA55AA);
        @(negedge ACLK);
        checkOutput("rst pre BREADY", 32'(BREADY), 32'd1);
        ARESETn = 1'b0;
        @(negedge ACLK);
        checkOutput("rst BREADY", 32'(BREADY), 32'd0);
        checkOutput("rst cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst AWADDR", AWADDR, 32'd0);
        @(negedge ACLK);
        ARESETn    = 1'b1;
        cfg_b_hold = 1'b0;
        repeat (3) @(negedge ACLK);
        checkOutput("rst no response", 32'(rsp_valid), 32'd0);
        applyStimulus(100, vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite master that converts a simple local command/response interface into AXI-Lite write and read transactions.
- Sits directly upstream of the team's AXI-Lite register slave and drives its AW/W/B/AR/R channels.
- Used by bus-verification benches and lightweight controllers to issue register accesses.
- Adds a per-transaction timeout so a hung slave cannot lock up the local side.

Parameters:
- ADDR_W, 32, address width of cmd_addr, AWADDR and ARADDR.
- DATA_W, 32, data width of cmd_wdata, WDATA, RDATA and rsp_rdata.
- TIMEOUT, 64, maximum cycles spent waiting in any AXI state; 0 disables the timeout.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  local command present
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transaction address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  local side accepts the response
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  AXI response code; 2'b11 = local timeout
- AWADDR  out  ADDR_W;  AWVALID  out  1;  AWREADY  in  1
- WDATA  out  DATA_W;  WVALID  out  1;  WREADY  in  1
- BRESP  in  2;  BVALID  in  1;  BREADY  out  1
- ARADDR  out  ADDR_W;  ARVALID  out  1;  ARREADY  in  1
- RDATA  in  DATA_W;  RRESP  in  2;  RVALID  in  1;  RREADY  out  1

Behaviour:
- All outputs are registered.
- Reset (ARESETn=0 at posedge ACLK): state=IDLE. cmd_ready=1. All of AWVALID, WVALID, BREADY, ARVALID, RREADY and rsp_valid are 0. AWADDR, WDATA, ARADDR, rsp_rdata, rsp_resp and rsp_write are 0. Timeout counter=0.
- Reset mid-transaction aborts the transaction immediately; no response is produced.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr/data/write and drop cmd_ready. A write goes to WR_AW_W with AWVALID=WVALID=1 on the next cycle. A read goes to RD_AR with ARVALID=1 on the next cycle.
  - WR_AW_W: AW and W are tracked independently. AWVALID clears the cycle after AWVALID&&AWREADY; WVALID clears the cycle after WVALID&&WREADY. Handshakes may occur in either order or in the same cycle. Once both are done, go to WR_B with BREADY=1.
  - WR_B: on BVALID&&BREADY, capture BRESP into rsp_resp, set rsp_write=1 and rsp_rdata=0, clear BREADY, go to RSP.
  - RD_AR: on ARVALID&&ARREADY, clear ARVALID, set RREADY=1, go to RD_R. A slave that asserts RVALID in the same cycle as ARREADY is handled: RVALID is sampled again in RD_R.
  - RD_R: on RVALID&&RREADY, capture RDATA and RRESP, set rsp_write=0, clear RREADY, go to RSP.
  - RSP: rsp_valid=1 and response fields stay stable until rsp_ready. On rsp_valid&&rsp_ready, clear rsp_valid, set cmd_ready=1, go to IDLE.
- No command is accepted while rsp_valid is pending; only one transaction is outstanding at a time.
- Minimum command-to-response latency with a zero-wait slave: write 3 cycles, read 3 cycles, from the cmd handshake to rsp_valid.
- Timeout: the counter resets on entry to each AXI state and increments every cycle spent in WR_AW_W, WR_B, RD_AR or RD_R. When TIMEOUT≠0 and the count reaches TIMEOUT, all AXI valid/ready outputs are dropped, rsp_resp=2'b11 and rsp_rdata=0, and the FSM goes to RSP. Late AXI handshakes arriving after a timeout are ignored.
- Address and data outputs hold their latched values until the next command (never X).
- The AXI protocol rule holds: a VALID, once asserted, is never dropped before its handshake, except on timeout or reset.

Test Plan:
- Write cmd addr=0x10, data=0xDEADBEEF to a zero-wait slave → AWVALID/WVALID rise 1 cycle after the cmd handshake, each clears after its handshake; rsp_valid with rsp_write=1 and rsp_resp=00.
- Read after that write from the same slave → ARVALID then RREADY; rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_write=0.
- Slave delays WREADY 3 cycles after AWREADY → AWVALID clears first, WVALID stays high until its handshake, then BREADY; exactly one response.
- rsp_ready held low for 5 cycles → rsp_valid and all rsp fields stable, cmd_ready=0, a cmd_valid pulse in this window is not accepted.
- TIMEOUT=8 with the slave never asserting ARREADY → ARVALID drops after 8 cycles; rsp_resp=11, rsp_rdata=0.
- ARESETn low during WR_B → BREADY=0, cmd_ready=1 and rsp_valid=0 after the reset edge; a following read completes normally.
